cpu_sequencer: RTL and testbench
================================

Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the 16-bit-instruction CPU datapath: instruction memory, decoder, register bank and ALU. It owns the PC and replaces the raw debounced-button clock with one system clock plus phase strobes: mem_en, ir_load, exec_en and wr_en. It supports two modes. Single-step advances one instruction per step-button edge. Free-run advances one instruction every RUN_DIV clocks. It sits between the debouncers and DIP switches on one side and the imem/reg_bank/ALU enables on the other.

Parameters:
PC_W, 16, PC / imem address width
TGT_W, 8, jump target width (ALU result); zero-extended into PC
MEM_LAT, 1, imem read latency in clocks (>=1)
RUN_DIV, 500000, clocks per instruction in run mode (>=8)
CNT_W, 16, retired-instruction counter width

Ports:
clk  in  1  system clock (clk_5 domain)
reset  in  1  synchronous, active-high
step  in  1  debounced step button, level; edge-detected internally
run  in  1  1 = free-run mode
jmp  in  1  from ALU, sampled in EXEC
jmp_target  in  TGT_W  ALU result, sampled in EXEC
wr_req  in  1  decoder write flag, sampled in EXEC
bp_addr  in  PC_W  breakpoint address (DIP data)
bp_en  in  1  breakpoint enable
pc  out  PC_W  program counter / imem address
mem_en  out  1  imem read strobe
ir_load  out  1  IR capture strobe
exec_en  out  1  ALU/flag update strobe
wr_en  out  1  register-bank write strobe
busy  out  1  high when not in IDLE
halted  out  1  breakpoint hit
instr_count  out  CNT_W  retired instructions, wraps

Behaviour:
- Reset values: state=IDLE, pc=0, all strobes 0, busy=0, halted=0, instr_count=0, step_q=0, run divider=0.
- Reset is synchronous. Asserting it mid-instruction forces IDLE on the next edge. No wr_en is issued and pc does not change.
- FSM states: IDLE -> FETCH -> WAIT -> DECODE -> EXEC -> WB -> IDLE.
- IDLE:
  - Starts a new instruction on a start event.
  - Start event in step mode (run=0): step rising edge, i.e. step & ~step_q.
  - Start event in run mode (run=1): divider reaches RUN_DIV-1 and halted=0.
- FETCH: mem_en=1 for one clock; pc is stable.
- WAIT: lasts MEM_LAT clocks.
- DECODE: ir_load=1 for one clock.
- EXEC: exec_en=1 for one clock. Latch jmp, jmp_target and wr_req.
- WB:
  - wr_en = latched wr_req, for one clock.
  - pc <= jmp ? zero-extended jmp_target : pc+1. pc+1 wraps from all-ones to 0.
  - instr_count increments, wrapping.
- Latency: start event to WB is 4+MEM_LAT clocks. Strobes are mutually exclusive one-hot pulses.
- Step edges while busy are ignored, not queued. Holding step executes exactly one instruction.
- Run divider:
  - Counts every clock while run=1, wrapping at RUN_DIV-1.
  - Held at 0 while run=0.
  - A terminal count while busy is dropped.
- Dropping run mid-instruction lets the current instruction complete; no further run starts.
- halted:
  - Set in WB when the breakpoint feature is compiled in, bp_en=1 and the next pc equals bp_addr.
  - While halted, run-mode starts are blocked.
  - A step edge clears halted and executes one instruction. That instruction may re-hit the breakpoint only if its next pc equals bp_addr again.
- Simultaneous run terminal count and step edge: one instruction starts.

Optional Feature:
CPU_SEQ_BREAKPOINT_EN.
- Defined: breakpoint compare and halted logic as above.
- Undefined: compare is removed, halted is tied to 0, and bp_addr and bp_en are ignored.

Decomposition:
- Shared package cpu_pkg holds:
  - FSM state encodings (IDLE..WB, 3 bits)
  - PC_W and TGT_W defaults
  - the one-hot strobe-vector constants
- One natural sub-module, seq_rate_div: the run-mode divider with terminal-count pulse output.
- Edge detect and FSM stay in the top.

Test Plan:
- Reset, then one step pulse with MEM_LAT=1 -> mem_en at cycle 1, ir_load at cycle 3, exec_en at cycle 4, wr_en (wr_req=1) at cycle 5; pc 0->1; instr_count=1; busy low at cycle 6.
- EXEC samples jmp=1, jmp_target=8'hA5 -> pc=16'h00A5 after WB; with jmp=0 at pc=16'hFFFF -> pc=0.
- step held high for 100 clocks -> exactly one instruction; second step pulse during busy -> ignored, instr_count=1.
- run=1, RUN_DIV=10, for 100 clocks -> instr_count=10, pc=10; drop run mid-EXEC -> instruction completes, no more starts.
- CPU_SEQ_BREAKPOINT_EN defined, bp_en=1, bp_addr=3, run=1 -> halted=1 with pc=3; run starts stop. Step edge -> halted=0, pc=4.
- Reset asserted in DECODE with wr_req=1 -> no wr_en, pc=0, state IDLE next clock.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the CPU control sequencer.
//   - seq_state_t : 3-bit FSM state encoding, IDLE..WB
//   - PC_W_DEF / TGT_W_DEF : default PC and jump-target widths
//   - STB_* : one-hot phase-strobe vectors, bit order {wr, exec, ir, mem}
//   - strobes_for() : strobe vector that is active while in a given state
package cpu_pkg;

  localparam int PC_W_DEF  = 16;
  localparam int TGT_W_DEF = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECODE = 3'd3,
    ST_EXEC   = 3'd4,
    ST_WB     = 3'd5
  } seq_state_t;

  localparam logic [3:0] STB_NONE = 4'b0000;
  localparam logic [3:0] STB_MEM  = 4'b0001;
  localparam logic [3:0] STB_IR   = 4'b0010;
  localparam logic [3:0] STB_EXEC = 4'b0100;
  localparam logic [3:0] STB_WR   = 4'b1000;

  // The WB write strobe is suppressed when the instruction does not write.
  function automatic logic [3:0] strobes_for(input seq_state_t s, input logic wr);
    logic [3:0] res;
    res = STB_NONE;
    case (s)
      ST_FETCH:  res = STB_MEM;
      ST_DECODE: res = STB_IR;
      ST_EXEC:   res = STB_EXEC;
      ST_WB:     res = wr ? STB_WR : STB_NONE;
      default:   res = STB_NONE;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/cpu_sequencer_rate_div.sv
// seq_rate_div: free-run instruction-rate divider.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   run        : count enable; the counter is held at 0 while low
//   tc         : high for the one clock in which the count sits at DIV-1
module seq_rate_div #(
  parameter int DIV = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tc
);

  localparam int W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // Divider counter: wraps at DIV-1, cleared whenever run is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tc = run & (cnt == LAST);

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control sequencer for the 16-bit-instruction CPU.
// Owns the PC and turns the system clock into one-hot phase strobes.
// Optional feature macro: CPU_SEQ_BREAKPOINT_EN (breakpoint compare / halted).
// Ports:
//   clk, reset          : system clock, synchronous active-high reset
//   step, run           : debounced step button (level) and free-run mode
//   jmp, jmp_target     : branch decision and target from the ALU (taken in EXEC)
//   wr_req              : decoder register-write flag (taken in EXEC)
//   bp_addr, bp_en      : breakpoint address and enable
//   pc                  : program counter / imem address
//   mem_en, ir_load,
//   exec_en, wr_en      : phase strobes, one-hot, one clock each
//   busy, halted        : not-IDLE flag, breakpoint-hit flag
//   instr_count         : retired-instruction counter, wraps
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int TGT_W   = TGT_W_DEF,
  parameter int MEM_LAT = 1,
  parameter int RUN_DIV = 500000,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step,
  input  logic             run,
  input  logic             jmp,
  input  logic [TGT_W-1:0] jmp_target,
  input  logic             wr_req,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic             bp_en,
  output logic [PC_W-1:0]  pc,
  output logic             mem_en,
  output logic             ir_load,
  output logic             exec_en,
  output logic             wr_en,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  localparam int LATW = $clog2(MEM_LAT + 1);

  seq_state_t       state;
  seq_state_t       next_state;
  logic             step_q;
  logic             step_rise;
  logic             step_start;
  logic             run_start;
  logic             start;
  logic             tc;
  logic [LATW-1:0]  wait_cnt;
  logic             wait_done;
  logic             jmp_q;
  logic [TGT_W-1:0] tgt_q;
  logic [PC_W-1:0]  next_pc;

  seq_rate_div #(.DIV(RUN_DIV)) u_rate_div (
    .clk   (clk),
    .reset (reset),
    .run   (run),
    .tc    (tc)
  );

  // A step edge starts an instruction in step mode, and also in run mode
  // when halted (it is the only way out of a breakpoint). A run terminal
  // count and a step edge in the same clock still start only one instruction.
  assign step_rise  = step & ~step_q;
  assign step_start = step_rise & (~run | halted);
  assign run_start  = tc & ~halted;
  assign start      = step_start | run_start;
  assign wait_done  = (wait_cnt == LATW'(MEM_LAT - 1));
  assign next_pc    = jmp_q ? PC_W'(tgt_q) : pc + 1'b1;

  // Next-state logic; starts and terminal counts outside IDLE are dropped.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          next_state = ST_FETCH;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_FETCH: next_state = ST_WAIT;
      ST_WAIT: begin
        if (wait_done) begin
          next_state = ST_DECODE;
        end else begin
          next_state = ST_WAIT;
        end
      end
      ST_DECODE: next_state = ST_EXEC;
      ST_EXEC:   next_state = ST_WB;
      ST_WB:     next_state = ST_IDLE;
      default:   next_state = ST_IDLE;
    endcase
  end

  // State register, registered strobes (decoded from the state being entered),
  // EXEC operand capture and WB retirement.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      step_q      <= 1'b0;
      pc          <= '0;
      mem_en      <= 1'b0;
      ir_load     <= 1'b0;
      exec_en     <= 1'b0;
      wr_en       <= 1'b0;
      busy        <= 1'b0;
      instr_count <= '0;
      wait_cnt    <= '0;
      jmp_q       <= 1'b0;
      tgt_q       <= '0;
    end else begin
      state  <= next_state;
      step_q <= step;
      // Entering WB only happens from EXEC, so wr_req here is the EXEC sample.
      {wr_en, exec_en, ir_load, mem_en} <= strobes_for(next_state, wr_req);
      busy   <= (next_state != ST_IDLE);
      if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt + 1'b1;
      end else begin
        wait_cnt <= '0;
      end
      if (state == ST_EXEC) begin
        jmp_q <= jmp;
        tgt_q <= jmp_target;
      end
      if (state == ST_WB) begin
        pc          <= next_pc;
        instr_count <= instr_count + 1'b1;
      end
    end
  end

`ifdef CPU_SEQ_BREAKPOINT_EN
  logic bp_hit;
  assign bp_hit = bp_en & (next_pc == bp_addr);

  // Breakpoint flag: set when the retiring instruction lands on bp_addr,
  // cleared by the step edge that launches the next instruction.
  always_ff @(posedge clk) begin
    if (reset) begin
      halted <= 1'b0;
    end else if ((state == ST_WB) && bp_hit) begin
      halted <= 1'b1;
    end else if ((state == ST_IDLE) && step_start) begin
      halted <= 1'b0;
    end
  end
`else
  logic unused_bp;
  assign unused_bp = ^{bp_addr, bp_en};
  assign halted    = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer. Reference model: an instruction is a fixed
// schedule of clock offsets from its start event (mem at +1, ir at +2+ML,
// exec at +3+ML, write/retire at +4+ML), plus the start/halt rules.
module tb_cpu_sequencer;

  localparam int PC_W  = 10;
  localparam int TGT_W = 8;
  localparam int ML    = 1;
  localparam int DIV   = 10;
  localparam int CNT_W = 16;
`ifdef CPU_SEQ_BREAKPOINT_EN
  localparam bit BP_ON = 1'b1;
`else
  localparam bit BP_ON = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             step = 1'b0;
  logic             run = 1'b0;
  logic             jmp = 1'b0;
  logic [TGT_W-1:0] jmp_target = '0;
  logic             wr_req = 1'b0;
  logic [PC_W-1:0]  bp_addr = '0;
  logic             bp_en = 1'b0;
  logic [PC_W-1:0]  pc;
  logic             mem_en, ir_load, exec_en, wr_en, busy, halted;
  logic [CNT_W-1:0] instr_count;

  int errors = 0;
  int checks = 0;

  cpu_sequencer #(
    .PC_W(PC_W), .TGT_W(TGT_W), .MEM_LAT(ML), .RUN_DIV(DIV), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .step(step), .run(run), .jmp(jmp),
    .jmp_target(jmp_target), .wr_req(wr_req), .bp_addr(bp_addr), .bp_en(bp_en),
    .pc(pc), .mem_en(mem_en), .ir_load(ir_load), .exec_en(exec_en),
    .wr_en(wr_en), .busy(busy), .halted(halted), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int               m_div;
  int               m_phase;   // clocks since start event, 0 = idle
  logic             m_step_q;
  logic [PC_W-1:0]  m_pc;
  logic [CNT_W-1:0] m_cnt;
  logic             m_halted;
  logic             m_jmp;
  logic [TGT_W-1:0] m_tgt;
  logic             m_wr;
  logic             m_step_start, m_start;
  logic [PC_W-1:0]  m_next_pc;

  assign m_step_start = step && !m_step_q && (!run || m_halted);
  assign m_start      = m_step_start || (run && (m_div == DIV - 1) && !m_halted);
  assign m_next_pc    = m_jmp ? PC_W'(m_tgt) : m_pc + 10'd1;

  always @(posedge clk) begin
    if (reset) begin
      m_div <= 0; m_phase <= 0; m_step_q <= 1'b0; m_pc <= '0; m_cnt <= '0;
      m_halted <= 1'b0; m_jmp <= 1'b0; m_tgt <= '0; m_wr <= 1'b0;
    end else begin
      m_step_q <= step;
      m_div    <= run ? (m_div + 1) % DIV : 0;
      if (m_phase == 0) begin
        if (m_start) begin
          m_phase <= 1;
          if (m_step_start) m_halted <= 1'b0;
        end
      end else if (m_phase == 4 + ML) begin
        m_pc    <= m_next_pc;
        m_cnt   <= m_cnt + 16'd1;
        m_phase <= 0;
        if (BP_ON && bp_en && (m_next_pc == bp_addr)) m_halted <= 1'b1;
      end else begin
        if (m_phase == 3 + ML) begin
          m_jmp <= jmp; m_tgt <= jmp_target; m_wr <= wr_req;
        end
        m_phase <= m_phase + 1;
      end
    end
  end

  function automatic logic [31:0] expv();
    return {m_pc, (m_phase == 1), (m_phase == 2 + ML), (m_phase == 3 + ML),
            ((m_phase == 4 + ML) && m_wr), (m_phase != 0), m_halted, m_cnt};
  endfunction

  function automatic logic [31:0] obsv();
    return {pc, mem_en, ir_load, exec_en, wr_en, busy, halted, instr_count};
  endfunction

  // Drive-only helper: one-clock step pulse, then idle long enough to retire.
  task automatic pulse_step_wait();
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; step = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (obsv() !== 32'h0) begin
      errors++;
      $display("FAIL reset_state dut=%h required=%h", obsv(), 32'h0);
    end
  endtask

  task automatic test_single_step();
    logic [4:0] exp_s;
    jmp = 1'b0; wr_req = 1'b1;
    step = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      step = 1'b0;
      exp_s = {(c == 1), (c == 3), (c == 4), (c == 5), (c >= 1 && c <= 5)};
      checks++;
      if ({mem_en, ir_load, exec_en, wr_en, busy} !== exp_s) begin
        errors++;
        $display("FAIL step_timing cycle=%0d dut=%b required=%b", c,
                 {mem_en, ir_load, exec_en, wr_en, busy}, exp_s);
      end
    end
    checks++;
    if (pc !== 10'd1 || instr_count !== 16'd1) begin
      errors++;
      $display("FAIL step_retire pc=%0d count=%0d required pc=1 count=1", pc, instr_count);
    end
  endtask

  task automatic test_jump_wrap();
    bit seen_top, wrapped;
    jmp = 1'b1; jmp_target = 8'hA5; wr_req = 1'b0;
    pulse_step_wait();
    checks++;
    if (pc !== 10'h0A5) begin
      errors++;
      $display("FAIL jump_a5 dut=%h required=%h", pc, 10'h0A5);
    end
    jmp_target = 8'hFF;
    pulse_step_wait();
    jmp = 1'b0;
    seen_top = 1'b0; wrapped = 1'b0;
    run = 1'b1;
    for (int i = 0; i < 8200 && !wrapped; i++) begin
      @(negedge clk);
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL wrap_cycle t=%0t dut=%h model=%h", $time, obsv(), expv());
      end
      if (pc == 10'h3FF) seen_top = 1'b1;
      if (seen_top && pc == 10'h000) wrapped = 1'b1;
    end
    run = 1'b0;
    checks++;
    if (!wrapped) begin
      errors++;
      $display("FAIL pc_wrap dut_pc=%h required wrap 3FF->000 within budget", pc);
    end
    repeat (10) @(negedge clk);
  endtask

  task automatic test_step_hold();
    logic [CNT_W-1:0] c0;
    c0 = instr_count;
    step = 1'b1; wr_req = 1'b1;
    repeat (100) begin
      @(negedge clk);
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL hold_cycle t=%0t dut=%h model=%h", $time, obsv(), expv());
      end
    end
    step = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_count !== c0 + 16'd1) begin
      errors++;
      $display("FAIL step_hold count=%0d required=%0d", instr_count, c0 + 16'd1);
    end
    // second edge while busy must be ignored
    step = 1'b1; @(negedge clk); step = 1'b0; @(negedge clk);
    step = 1'b1; @(negedge clk); step = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (instr_count !== c0 + 16'd2) begin
      errors++;
      $display("FAIL busy_edge count=%0d required=%0d", instr_count, c0 + 16'd2);
    end
  endtask

  task automatic test_run();
    logic [CNT_W-1:0] k;
    bit found;
    do_reset();
    jmp = 1'b0; wr_req = 1'b0;
    run = 1'b1;
    repeat (100) begin
      @(negedge clk);
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL run_cycle t=%0t dut=%h model=%h", $time, obsv(), expv());
      end
    end
    run = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (instr_count !== 16'd10 || pc !== 10'd10) begin
      errors++;
      $display("FAIL run_100 count=%0d pc=%0d required count=10 pc=10", instr_count, pc);
    end
    run = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (exec_en) found = 1'b1;
    end
    run = 1'b0;
    k = instr_count;
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL run_exec_wait exec_en=%b required exec_en seen within 40 clocks", exec_en);
    end
    repeat (30) @(negedge clk);
    checks++;
    if (instr_count !== k + 16'd1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL run_drop count=%0d busy=%b required count=%0d busy=0",
               instr_count, busy, k + 16'd1);
    end
  endtask

  task automatic test_breakpoint();
    logic [PC_W-1:0] exp_pc;
    do_reset();
    jmp = 1'b0; bp_en = 1'b1; bp_addr = 10'd3;
    run = 1'b1;
    repeat (100) begin
      @(negedge clk);
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL bp_cycle t=%0t dut=%h model=%h", $time, obsv(), expv());
      end
    end
    exp_pc = BP_ON ? 10'd3 : 10'd9;
    checks++;
    if (halted !== BP_ON || pc !== exp_pc) begin
      errors++;
      $display("FAIL bp_hit halted=%b pc=%0d required halted=%b pc=%0d", halted, pc, BP_ON, exp_pc);
    end
    run = 1'b0;
    repeat (10) @(negedge clk);
    pulse_step_wait();
    exp_pc = BP_ON ? 10'd4 : 10'd11;
    checks++;
    if (halted !== 1'b0 || pc !== exp_pc) begin
      errors++;
      $display("FAIL bp_step halted=%b pc=%0d required halted=0 pc=%0d", halted, pc, exp_pc);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_reset_decode();
    do_reset();
    wr_req = 1'b1; step = 1'b1;
    repeat (3) begin
      @(negedge clk);
      step = 1'b0;
    end
    reset = 1'b1;   // DUT is in DECODE now
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if ({busy, wr_en, mem_en, ir_load, exec_en} !== 5'b0 || pc !== 10'd0) begin
      errors++;
      $display("FAIL reset_decode busy=%b wr_en=%b pc=%0d required idle, no strobes, pc=0",
               busy, wr_en, pc);
    end
    repeat (6) begin
      @(negedge clk);
      checks++;
      if (wr_en !== 1'b0 || instr_count !== 16'd0) begin
        errors++;
        $display("FAIL reset_no_wb wr_en=%b count=%0d required 0 0", wr_en, instr_count);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (3000) begin
      @(negedge clk);
      checks++;
      if (obsv() !== expv()) begin
        errors++;
        $display("FAIL rand_cycle t=%0t dut=%h model=%h", $time, obsv(), expv());
      end
      if ($urandom_range(0, 7) == 0) step = ~step;
      if ($urandom_range(0, 99) == 0) run = ~run;
      if ($urandom_range(0, 49) == 0) begin
        bp_en = 1'($urandom_range(0, 1));
        bp_addr = PC_W'($urandom_range(0, 15));
      end
      jmp        = ($urandom_range(0, 3) == 0);
      jmp_target = TGT_W'($urandom_range(0, 15));
      wr_req     = 1'($urandom_range(0, 1));
      reset      = ($urandom_range(0, 499) == 0);
    end
    reset = 1'b0; run = 1'b0; step = 1'b0; bp_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_step();
    test_jump_wrap();
    test_step_hold();
    test_run();
    test_breakpoint();
    test_reset_decode();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
